// File: rtl/if_stage_pkg.sv
// Shared widths, FSM encoding and bus layouts for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned PsToFsBusWd = 41;
  localparam int unsigned FsToDsBusWd = 73;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StExc   = 2'd3
  } fs_state_e;

  typedef struct packed {
    logic        s0_ex;
    logic        s0_refill_ex;
    logic [5:0]  ecode;
    logic        ps_ex;
    logic [31:0] pc;
  } ps_to_fs_t;

  function automatic logic [FsToDsBusWd-1:0] pack_fs_bus(input ps_to_fs_t ps,
                                                         input logic [31:0] inst);
    return {ps.s0_ex, ps.s0_refill_ex, ps.ecode, ps.ps_ex, inst, ps.pc};
  endfunction

endpackage

// File: rtl/if_stage.sv
// IF stage: tracks one outstanding fetch, drops stale returns, and hands instructions or
// pre-IF exceptions to ID.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ps_to_fs_valid,
  input  logic [PsToFsBusWd-1:0] ps_to_fs_bus,
  output logic                   fs_allowin,
  input  logic                   data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic                   wrongPC_br,
  input  logic                   wrong_req_r,
  input  logic                   fs_flush,
  input  logic                   br_cancel,
  input  logic                   ds_allowin,
  output logic                   fs_to_ds_valid,
  output logic [FsToDsBusWd-1:0] fs_to_ds_bus
);

  fs_state_e   state_q, state_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  ps_to_fs_t   ps_bus_q;
  logic [31:0] inst_q;
  logic [31:0] inst_cur;

  logic kill;
  logic in_wait;
  logic data_stale;
  logic data_own;
  logic load;

  assign kill       = fs_flush | br_cancel;
  assign in_wait    = (state_q == StWait);
  assign data_stale = data_ok & (drop_cnt_q != 2'd0);
  assign data_own   = in_wait & data_ok & (drop_cnt_q == 2'd0) & ~wrongPC_br & ~wrong_req_r;

  assign fs_to_ds_valid = ((state_q == StHold) | (state_q == StExc) | data_own) & ~kill;
  assign fs_allowin     = ((state_q == StEmpty) | (fs_to_ds_valid & ds_allowin)) & ~kill;
  assign load           = ps_to_fs_valid & fs_allowin;

  always_comb begin
    inst_cur = inst_q;
    if (state_q == StExc) begin
      inst_cur = 32'h0;
    end else if (in_wait) begin
      inst_cur = inst_sram_rdata;
    end
  end

  assign fs_to_ds_bus = pack_fs_bus(ps_bus_q, inst_cur);

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = StEmpty;
    end else if (load) begin
      state_d = ps_to_fs_bus[32] ? StExc : StWait;
    end else if (fs_to_ds_valid & ds_allowin) begin
      state_d = StEmpty;
    end else if (data_own) begin
      state_d = StHold;
    end
  end

  // A kill in WAIT orphans the outstanding request unless its own word arrives now; a stale
  // return in the same cycle retires an older orphan, so the count nets out unchanged.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_wait & kill & ~data_own) begin
      if (!data_stale && drop_cnt_q != 2'd3) begin
        drop_cnt_d = drop_cnt_q + 2'd1;
      end
    end else if (data_stale) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StEmpty;
      drop_cnt_q <= 2'd0;
      ps_bus_q   <= '0;
      inst_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      if (load) begin
        ps_bus_q <= ps_to_fs_bus;
      end
      if (data_own) begin
        inst_q <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; ID transfers are checked against a scoreboard queue.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   ps_to_fs_valid;
  logic [PsToFsBusWd-1:0] ps_to_fs_bus;
  logic                   fs_allowin;
  logic                   data_ok;
  logic [31:0]            inst_sram_rdata;
  logic                   wrongPC_br;
  logic                   wrong_req_r;
  logic                   fs_flush;
  logic                   br_cancel;
  logic                   ds_allowin;
  logic                   fs_to_ds_valid;
  logic [FsToDsBusWd-1:0] fs_to_ds_bus;

  logic [72:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ps_to_fs_valid  (ps_to_fs_valid),
    .ps_to_fs_bus    (ps_to_fs_bus),
    .fs_allowin      (fs_allowin),
    .data_ok         (data_ok),
    .inst_sram_rdata (inst_sram_rdata),
    .wrongPC_br      (wrongPC_br),
    .wrong_req_r     (wrong_req_r),
    .fs_flush        (fs_flush),
    .br_cancel       (br_cancel),
    .ds_allowin      (ds_allowin),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  function automatic logic [40:0] mk_ps(input logic [5:0] ecode, input logic ex,
                                        input logic [31:0] pc);
    return {1'b0, 1'b0, ecode, ex, pc};
  endfunction

  function automatic logic [72:0] mk_fs(input logic [5:0] ecode, input logic ex,
                                        input logic [31:0] inst, input logic [31:0] pc);
    return {1'b0, 1'b0, ecode, ex, inst, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; leaves the DUT in WAIT.
  task automatic issue(input logic [31:0] pc);
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(6'h0, 1'b0, pc);
    tick();
    ps_to_fs_valid = 1'b0;
  endtask

  // Monitor: every accepted hand-off to ID must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && fs_to_ds_valid && ds_allowin) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got %h required no transfer", fs_to_ds_bus);
      end else begin
        check("id_xfer", fs_to_ds_bus, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn          = 1'b0;
    ps_to_fs_valid  = 1'b0;
    ps_to_fs_bus    = '0;
    data_ok         = 1'b0;
    inst_sram_rdata = 32'h0;
    wrongPC_br      = 1'b0;
    wrong_req_r     = 1'b0;
    fs_flush        = 1'b0;
    br_cancel       = 1'b0;
    ds_allowin      = 1'b1;
    #12;
    check("rst_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    check("rst_bus", fs_to_ds_bus, 73'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("rst_allowin", 73'(fs_allowin), 73'(1'b1));
    check("rst_state", 73'(dut.state_q), 73'(StEmpty));
    check("rst_drop", 73'(dut.drop_cnt_q), 73'(0));
    tick();

    // Straight-through fetch, data_ok two cycles after the request.
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(6'h0, 1'b0, 32'h1c000000);
    #1 check("allowin_empty", 73'(fs_allowin), 73'(1'b1));
    tick();
    ps_to_fs_valid = 1'b0;
    tick();
    data_ok         = 1'b1;
    inst_sram_rdata = 32'h02800000;
    exp_q.push_back(mk_fs(6'h0, 1'b0, 32'h02800000, 32'h1c000000));
    #1 check("pass_valid", 73'(fs_to_ds_valid), 73'(1'b1));
    tick();
    data_ok = 1'b0;
    #1 check("pass_state", 73'(dut.state_q), 73'(StEmpty));

    // ID stalled at data_ok: buffer in HOLD, bus stable until released.
    issue(32'h1c000010);
    data_ok         = 1'b1;
    inst_sram_rdata = 32'h12345678;
    ds_allowin      = 1'b0;
    #1 check("hold_allowin0", 73'(fs_allowin), 73'(1'b0));
    tick();
    data_ok         = 1'b0;
    inst_sram_rdata = 32'hdeadbeef;
    #1 check("hold_state", 73'(dut.state_q), 73'(StHold));
    check("hold_bus0", fs_to_ds_bus, mk_fs(6'h0, 1'b0, 32'h12345678, 32'h1c000010));
    tick();
    check("hold_bus1", fs_to_ds_bus, mk_fs(6'h0, 1'b0, 32'h12345678, 32'h1c000010));
    exp_q.push_back(mk_fs(6'h0, 1'b0, 32'h12345678, 32'h1c000010));
    ds_allowin = 1'b1;
    #1 check("hold_release_allowin", 73'(fs_allowin), 73'(1'b1));
    tick();
    check("hold_release_state", 73'(dut.state_q), 73'(StEmpty));

    // Flush while holding: back to EMPTY, nothing to drop.
    issue(32'h1c000014);
    data_ok         = 1'b1;
    inst_sram_rdata = 32'h55555555;
    ds_allowin      = 1'b0;
    tick();
    data_ok  = 1'b0;
    fs_flush = 1'b1;
    #1 check("holdflush_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    tick();
    fs_flush   = 1'b0;
    ds_allowin = 1'b1;
    #1 check("holdflush_state", 73'(dut.state_q), 73'(StEmpty));
    check("holdflush_drop", 73'(dut.drop_cnt_q), 73'(0));

    // Branch cancel in WAIT, then the orphaned word is dropped ahead of the new one.
    issue(32'h1c000004);
    br_cancel = 1'b1;
    #1 check("brc_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    check("brc_allowin", 73'(fs_allowin), 73'(1'b0));
    tick();
    br_cancel = 1'b0;
    #1 check("brc_drop1", 73'(dut.drop_cnt_q), 73'(1));
    check("brc_state", 73'(dut.state_q), 73'(StEmpty));
    issue(32'h1c000100);
    data_ok         = 1'b1;
    inst_sram_rdata = 32'haaaa0000;
    #1 check("brc_stale_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    tick();
    check("brc_drop0", 73'(dut.drop_cnt_q), 73'(0));
    check("brc_wait", 73'(dut.state_q), 73'(StWait));
    inst_sram_rdata = 32'hbbbb0000;
    exp_q.push_back(mk_fs(6'h0, 1'b0, 32'hbbbb0000, 32'h1c000100));
    tick();
    data_ok = 1'b0;

    // Pre-IF exception: presented next cycle without any data_ok.
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(6'h08, 1'b1, 32'h1c000002);
    tick();
    ps_to_fs_valid = 1'b0;
    exp_q.push_back(mk_fs(6'h08, 1'b1, 32'h0, 32'h1c000002));
    #1 check("exc_valid", 73'(fs_to_ds_valid), 73'(1'b1));
    tick();
    check("exc_state", 73'(dut.state_q), 73'(StEmpty));

    // Wrong-path returns are dropped without touching drop_cnt.
    issue(32'h1c000008);
    data_ok         = 1'b1;
    wrongPC_br      = 1'b1;
    inst_sram_rdata = 32'h11111111;
    #1 check("wpc_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    tick();
    wrongPC_br      = 1'b0;
    wrong_req_r     = 1'b1;
    inst_sram_rdata = 32'h12121212;
    #1 check("wpc_state", 73'(dut.state_q), 73'(StWait));
    check("wpc_drop", 73'(dut.drop_cnt_q), 73'(0));
    check("wrq_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    tick();
    wrong_req_r     = 1'b0;
    inst_sram_rdata = 32'h22222222;
    exp_q.push_back(mk_fs(6'h0, 1'b0, 32'h22222222, 32'h1c000008));
    tick();
    data_ok = 1'b0;

    // Flush coincident with data_ok: word discarded, no drop pending.
    issue(32'h1c00000c);
    fs_flush        = 1'b1;
    data_ok         = 1'b1;
    inst_sram_rdata = 32'h33333333;
    #1 check("flushok_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    tick();
    fs_flush = 1'b0;
    data_ok  = 1'b0;
    #1 check("flushok_drop", 73'(dut.drop_cnt_q), 73'(0));
    check("flushok_state", 73'(dut.state_q), 73'(StEmpty));

    // drop_cnt saturates at 3, then drains one per data_ok; extra data_ok is ignored.
    for (int i = 0; i < 4; i++) begin
      issue(32'h1c000200 + 32'(4 * i));
      br_cancel = 1'b1;
      tick();
      br_cancel = 1'b0;
      #1 check("sat_drop", 73'(dut.drop_cnt_q), 73'((i < 3) ? i + 1 : 3));
    end
    data_ok = 1'b1;
    repeat (3) tick();
    check("drain_drop", 73'(dut.drop_cnt_q), 73'(0));
    tick();
    data_ok = 1'b0;
    #1 check("spurious_drop", 73'(dut.drop_cnt_q), 73'(0));
    check("spurious_state", 73'(dut.state_q), 73'(StEmpty));

    // Reset in WAIT with a drop pending clears everything asynchronously.
    issue(32'h1c000300);
    br_cancel = 1'b1;
    tick();
    br_cancel = 1'b0;
    issue(32'h1c000304);
    #2 resetn = 1'b0;
    #1 check("arst_valid", 73'(fs_to_ds_valid), 73'(1'b0));
    check("arst_state", 73'(dut.state_q), 73'(StEmpty));
    check("arst_drop", 73'(dut.drop_cnt_q), 73'(0));
    check("arst_bus", fs_to_ds_bus, 73'(0));
    tick();
    resetn = 1'b1;
    #1 check("arst_allowin", 73'(fs_allowin), 73'(1'b1));

    repeat (3) tick();
    check("scoreboard_drained", 73'(exp_q.size()), 73'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
